// File: rtl/seg7_pkg.sv
// Shared definitions for the multi-digit seven-segment value display.
//   - Segment glyph codes in active-low form, bit order g..a (bit 6 = g).
//   - FSM state type for the display controller.
//   - Helper functions for sizing the BCD register and padded nibble vectors.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  // Every 3 input bits need at most one BCD digit (log2(10) > 3).
  function automatic int bcd_w(input int data_w);
    return 4 * ((data_w + 2) / 3);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational nibble to seven-segment decoder.
//   nibble : hex digit to show (0..F)
//   blank  : force all segments off
//   dash   : force the dash glyph (segment g only); wins over blank
//   seg    : segment drive, bit order g..a, polarity set by SEG_AL
module seg7_decoder
  import seg7_pkg::*;
#(
  parameter int SEG_AL = 1
) (
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  logic [6:0] code_al;

  always_comb begin
    code_al = SEG_BLANK;
    if (dash) begin
      code_al = SEG_DASH;
    end else if (blank) begin
      code_al = SEG_BLANK;
    end else begin
      case (nibble)
        4'h0: code_al = SEG_0;
        4'h1: code_al = SEG_1;
        4'h2: code_al = SEG_2;
        4'h3: code_al = SEG_3;
        4'h4: code_al = SEG_4;
        4'h5: code_al = SEG_5;
        4'h6: code_al = SEG_6;
        4'h7: code_al = SEG_7;
        4'h8: code_al = SEG_8;
        4'h9: code_al = SEG_9;
        4'hA: code_al = SEG_A;
        4'hB: code_al = SEG_B;
        4'hC: code_al = SEG_C;
        4'hD: code_al = SEG_D;
        4'hE: code_al = SEG_E;
        4'hF: code_al = SEG_F;
      endcase
    end
  end

  assign seg = (SEG_AL != 0) ? code_al : ~code_al;

endmodule

// File: rtl/seg7_value_display.sv
// Multi-digit seven-segment driver for a DATA_W-bit value, hex or decimal.
// Decimal goes through a sequential double-dabble converter (one bit per clock).
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   value    : value to show, captured when a load is accepted
//   load     : display update request, accepted only while idle
//   mode_dec : 0 = hex, 1 = unsigned decimal (captured with value)
//   blank_lz : 1 = blank leading zeros (captured with value)
//   segments : digit k on [7k+6:7k], digit 0 least significant, bit order g..a
//   busy     : conversion in progress; loads are dropped
//   done     : one-cycle pulse when segments were updated
//   overflow : last committed value did not fit in DIGITS digits
module seg7_value_display
  import seg7_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DIGITS = 4,
  parameter int SEG_AL = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_W-1:0]     value,
  input  logic                  load,
  input  logic                  mode_dec,
  input  logic                  blank_lz,
  output logic [7*DIGITS-1:0]   segments,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int BCD_W = bcd_w(DATA_W);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int RAW_W = max_int(max_int(BCD_W, DATA_W), 4 * DIGITS);
  localparam int SRC_W = 4 * ((RAW_W + 3) / 4);
  localparam logic [6:0] BLANK_CODE = (SEG_AL != 0) ? SEG_BLANK : ~SEG_BLANK;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   sh;
  logic [BCD_W-1:0]    bcd;
  logic                dec_q;
  logic                blz_q;
  logic                accept;

  logic [SRC_W-1:0]    src;
  logic                ovf_nxt;
  logic [DIGITS-1:0]   lz_blank;
  logic [7*DIGITS-1:0] seg_nxt;

  // Double-dabble correction: any BCD digit of 5 or more would exceed 9 after
  // the following shift, so add 3 first.
  function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  assign accept = (state == IDLE) && load;
  assign busy   = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = mode_dec ? CONVERT : COMMIT;
      CONVERT: if (cnt == CNT_W'(DATA_W - 1)) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= '0;
      end else if (state == CONVERT) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Capture / conversion stage: hex keeps the raw value in sh, decimal
  // shifts it into bcd one bit per clock.
  always_ff @(posedge clk) begin
    if (accept) begin
      sh    <= value;
      bcd   <= '0;
      dec_q <= mode_dec;
      blz_q <= blank_lz;
    end else if (state == CONVERT) begin
      {bcd, sh} <= {add3_all(bcd), sh} << 1;
    end
  end

  // Commit stage: digit nibbles, overflow and blanking feed the decoders.
  assign src = dec_q ? SRC_W'(bcd) : SRC_W'(sh);

  always_comb begin
    ovf_nxt = 1'b0;
    for (int i = 4 * DIGITS; i < SRC_W; i++) begin
      ovf_nxt = ovf_nxt | src[i];
    end
  end

  // Walk from the top digit down; a digit is blank while it and every digit
  // above it are zero. Digit 0 always shows.
  always_comb begin
    logic nz_above;
    nz_above = 1'b0;
    lz_blank = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      nz_above    = nz_above | (|src[4*k +: 4]);
      lz_blank[k] = blz_q & ~nz_above;
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    seg7_decoder #(
      .SEG_AL (SEG_AL)
    ) u_dec (
      .nibble (src[4*k +: 4]),
      .blank  (lz_blank[k]),
      .dash   (ovf_nxt),
      .seg    (seg_nxt[7*k +: 7])
    );
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      segments <= {DIGITS{BLANK_CODE}};
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (state == COMMIT);
      if (state == COMMIT) begin
        segments <= seg_nxt;
        overflow <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seg7_value_display.sv
module tb_seg7_value_display;

  localparam int DATA_W = 32;
  localparam int DIGITS = 4;
  localparam int SEGW   = 7 * DIGITS;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic [DATA_W-1:0] value = '0;
  logic              load = 1'b0;
  logic              mode_dec = 1'b0;
  logic              blank_lz = 1'b0;
  logic [SEGW-1:0]   segments;
  logic              busy;
  logic              done;
  logic              overflow;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [SEGW-1:0] seg;
    logic            ovf;
    int              cyc;
    logic [31:0]     v;
  } exp_t;
  exp_t exp_q[$];

  logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;

  seg7_value_display #(.DATA_W(DATA_W), .DIGITS(DIGITS), .SEG_AL(1)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .value    (value),
    .load     (load),
    .mode_dec (mode_dec),
    .blank_lz (blank_lz),
    .segments (segments),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: digits by repeated division in the chosen base.
  task automatic model(input logic [31:0] v, input bit dec, input bit blz,
                       output logic [SEGW-1:0] seg, output logic ovf);
    longint unsigned vv, base, p, d;
    vv = v;
    base = dec ? 10 : 16;
    p = 1;
    seg = '0;
    for (int k = 0; k < DIGITS; k++) begin
      d = (vv / p) % base;
      if (blz && k > 0 && vv < p) seg[7*k +: 7] = BLANK;
      else seg[7*k +: 7] = glyph[int'(d)];
      p = p * base;
    end
    ovf = (vv >= p);
    if (ovf) seg = {DIGITS{DASH}};
  endtask

  task automatic issue(input logic [31:0] v, input bit dec, input bit blz);
    int guard;
    exp_t e;
    guard = 0;
    while (busy !== 1'b0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      failures++;
      $display("FAIL issue_idle_timeout actual=busy required=idle");
    end
    value = v;
    mode_dec = dec;
    blank_lz = blz;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    model(v, dec, blz, e.seg, e.ovf);
    e.cyc = cyc + (dec ? DATA_W + 1 : 1);
    e.v = v;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int exp_busy);
    int n;
    int bc;
    bit seen;
    n = 0;
    bc = 0;
    seen = 0;
    while (n < 200 && !seen) begin
      @(negedge clk);
      n++;
      if (busy === 1'b1) bc++;
      if (done === 1'b1) seen = 1;
    end
    chk("done_seen", 64'(seen), 64'd1);
    chk("busy_cycles", 64'(bc), 64'(exp_busy));
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=done required=no_done cyc=%0d", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("segments_v%0h", e.v), 64'(segments), 64'(e.seg));
        chk($sformatf("overflow_v%0h", e.v), 64'(overflow), 64'(e.ovf));
        chk($sformatf("latency_v%0h", e.v), 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    logic [31:0] rv;
    bit rd, rb;

    // Reset asserted between edges must take effect at once.
    repeat (1) @(posedge clk);
    #8 reset_n = 1'b0;
    #1;
    chk("rst_segments", 64'(segments), 64'h0FFFFFFF);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(negedge clk);

    issue(32'h0000BEEF, 0, 0);
    chk("hex_busy_after_accept", 64'(busy), 64'd1);
    wait_done(1);

    issue(32'd1234, 1, 0);
    wait_done(DATA_W + 1);

    issue(32'd12345, 1, 0);
    wait_done(DATA_W + 1);
    issue(32'h0001_0000, 0, 0);
    wait_done(1);

    issue(32'd7, 1, 1);
    wait_done(DATA_W + 1);
    issue(32'd0, 1, 1);
    wait_done(DATA_W + 1);
    issue(32'h0000_0A00, 0, 1);
    wait_done(1);

    // Load during conversion is dropped.
    issue(32'd9876, 1, 0);
    repeat (5) @(posedge clk);
    #1;
    value = 32'd1111;
    mode_dec = 1'b0;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    wait_done(DATA_W + 1 - 6);
    // Segments must hold after the commit even as inputs wiggle.
    value = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    begin
      logic [SEGW-1:0] hs;
      logic ho;
      model(32'd9876, 1, 0, hs, ho);
      chk("hold_segments", 64'(segments), 64'(hs));
    end

    // Reset mid-conversion aborts with no done pulse.
    issue(32'd5555, 1, 0);
    repeat (10) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("midrst_segments", 64'(segments), 64'h0FFFFFFF);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_overflow", 64'(overflow), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_segments_held", 64'(segments), 64'h0FFFFFFF);

    issue(32'd42, 1, 0);
    wait_done(DATA_W + 1);

    // Randomized, back-to-back (next load lands in the done cycle).
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: rv = $urandom;
        1: rv = $urandom_range(0, 9999);
        2: rv = $urandom_range(0, 20);
        default: rv = $urandom_range(0, 32'h0001_FFFF);
      endcase
      rd = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      issue(rv, rd, rb);
      wait_done(rd ? DATA_W + 1 : 1);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
